// File: rtl/instr_mem_loader.sv
// rtl/instr_mem_loader.sv - word-organised instruction memory with registered fetch port, streaming loader and post-reset clear sweep
//
// Purpose: instruction store for the IF stage. Fetches are accepted only in
// IDLE and return one cycle later. A loader burst writes program words at run
// time. An optional sweep zeroes every word after reset.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   fetch_req/fetch_addr       fetch request and byte address (PC)
//   fetch_stall                holds fetch outputs and blocks acceptance
//   fetch_ready                high in IDLE
//   instr_valid/instruction    registered fetch result (big-endian word)
//   fetch_fault                [0] misaligned, [1] out of range
//   load_start/load_base       begin a load burst at a byte address (IDLE only)
//   load_valid/load_data       one word per beat
//   load_last                  marks the final word of the burst
//   load_ready                 high in LOAD
//   busy                       high in CLEAR or LOAD
module instr_mem_loader #(
  parameter int DEPTH_BYTES    = 16384,
  parameter int ADDR_WIDTH     = 32,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fetch_req,
  input  logic [ADDR_WIDTH-1:0] fetch_addr,
  input  logic                  fetch_stall,
  output logic                  fetch_ready,
  output logic                  instr_valid,
  output logic [31:0]           instruction,
  output logic [1:0]            fetch_fault,
  input  logic                  load_start,
  input  logic [ADDR_WIDTH-1:0] load_base,
  input  logic                  load_valid,
  input  logic [31:0]           load_data,
  input  logic                  load_last,
  output logic                  load_ready,
  output logic                  busy
);

  localparam int WORDS   = DEPTH_BYTES / 4;
  localparam int BYTE_AW = $clog2(DEPTH_BYTES);
  localparam int WIDX    = BYTE_AW - 2;
  localparam logic [WIDX-1:0] LAST_WORD = WIDX'(WORDS - 1);

  localparam logic [1:0] S_CLEAR = 2'd0;
  localparam logic [1:0] S_IDLE  = 2'd1;
  localparam logic [1:0] S_LOAD  = 2'd2;

  logic [1:0]      state;
  logic [WIDX-1:0] clr_ptr;
  logic [WIDX-1:0] load_ptr;
  logic [31:0]     mem [WORDS];

  logic            fetch_accept;
  logic            fault_misal;
  logic            fault_range;
  logic [WIDX-1:0] fetch_idx;
  logic            mem_we;
  logic [WIDX-1:0] mem_waddr;
  logic [31:0]     mem_wdata;

  // Load base keeps only the word index inside the array; the rest is
  // discarded by the modulo addressing.
  logic unused_load_base;
  assign unused_load_base = &{1'b0, load_base[ADDR_WIDTH-1:BYTE_AW], load_base[1:0]};

  assign fetch_ready = (state == S_IDLE);
  assign load_ready  = (state == S_LOAD);
  assign busy        = (state != S_IDLE);

  assign fault_misal  = |fetch_addr[1:0];
  // DEPTH_BYTES is a power of two, so any set bit above the byte index is out of range.
  assign fault_range  = |fetch_addr[ADDR_WIDTH-1:BYTE_AW];
  assign fetch_idx    = fetch_addr[BYTE_AW-1:2];
  assign fetch_accept = (state == S_IDLE) && fetch_req && !fetch_stall;

  // Single write port shared by the clear sweep and the loader. Gated by
  // rst_n so a held reset never touches the array.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = load_ptr;
    mem_wdata = load_data;
    if (rst_n) begin
      if (state == S_CLEAR) begin
        mem_we    = 1'b1;
        mem_waddr = clr_ptr;
        mem_wdata = 32'h0;
      end else if (state == S_LOAD && load_valid) begin
        mem_we = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= CLEAR_ON_RESET ? S_CLEAR : S_IDLE;
      clr_ptr  <= '0;
      load_ptr <= '0;
    end else begin
      case (state)
        S_CLEAR: begin
          clr_ptr <= clr_ptr + 1'b1;
          if (clr_ptr == LAST_WORD) begin
            state <= S_IDLE;
          end
        end
        S_IDLE: begin
          if (load_start) begin
            state    <= S_LOAD;
            load_ptr <= load_base[BYTE_AW-1:2];
          end
        end
        S_LOAD: begin
          if (load_valid) begin
            // Natural wrap of the word index gives the modulo-DEPTH advance.
            load_ptr <= load_ptr + 1'b1;
            if (load_last) begin
              state <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Fetch result registers: frozen while stalled; otherwise instr_valid
  // tracks acceptance and the data/fault fields load only on acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_valid <= 1'b0;
      instruction <= 32'h0;
      fetch_fault <= 2'b00;
    end else if (!fetch_stall) begin
      instr_valid <= fetch_accept;
      if (fetch_accept) begin
        fetch_fault <= {fault_range, fault_misal};
        instruction <= (fault_range || fault_misal) ? 32'h0 : mem[fetch_idx];
      end
    end
  end

endmodule
